// File: rtl/fabric_port_arbiter_if.sv
// Signal bundle between the I/D masters, the arbiter and one OCP slave port.
// The arbiter uses the slave modport; the fabric/environment side uses master.
interface fabric_port_arbiter_if;
   logic [31:0] i_I_MAddr;
   logic [2:0]  i_I_MCmd;
   logic [31:0] i_I_MData;
   logic [3:0]  i_I_MByteEn;
   logic        o_I_SCmdAccept;
   logic [31:0] o_I_SData;
   logic [1:0]  o_I_SResp;

   logic [31:0] i_D_MAddr;
   logic [2:0]  i_D_MCmd;
   logic [31:0] i_D_MData;
   logic [3:0]  i_D_MByteEn;
   logic        o_D_SCmdAccept;
   logic [31:0] o_D_SData;
   logic [1:0]  o_D_SResp;

   logic [31:0] o_P_MAddr;
   logic [2:0]  o_P_MCmd;
   logic [31:0] o_P_MData;
   logic [3:0]  o_P_MByteEn;
   logic        i_P_SCmdAccept;
   logic [31:0] i_P_SData;
   logic [1:0]  i_P_SResp;

   modport slave (
      input  i_I_MAddr, i_I_MCmd, i_I_MData, i_I_MByteEn,
      output o_I_SCmdAccept, o_I_SData, o_I_SResp,
      input  i_D_MAddr, i_D_MCmd, i_D_MData, i_D_MByteEn,
      output o_D_SCmdAccept, o_D_SData, o_D_SResp,
      output o_P_MAddr, o_P_MCmd, o_P_MData, o_P_MByteEn,
      input  i_P_SCmdAccept, i_P_SData, i_P_SResp
   );

   modport master (
      output i_I_MAddr, i_I_MCmd, i_I_MData, i_I_MByteEn,
      input  o_I_SCmdAccept, o_I_SData, o_I_SResp,
      output i_D_MAddr, i_D_MCmd, i_D_MData, i_D_MByteEn,
      input  o_D_SCmdAccept, o_D_SData, o_D_SResp,
      input  o_P_MAddr, o_P_MCmd, o_P_MData, o_P_MByteEn,
      output i_P_SCmdAccept, i_P_SData, i_P_SResp
   );
endinterface

// File: rtl/fabric_port_arbiter.sv
// Round-robin share of one OCP slave port between the I and D masters, one
// transaction in flight; idle-neutral outputs let the fabric AND/OR across ports.
module fabric_port_arbiter #(
   parameter int unsigned PORT    = 0,
   parameter int unsigned SEL_MSB = 31,
   parameter int unsigned SEL_LSB = 29,
   parameter int unsigned TIMEOUT = 255
) (
   input logic                  clk,
   input logic                  rst,
   fabric_port_arbiter_if.slave bus
);

   localparam int unsigned     SelW     = SEL_MSB - SEL_LSB + 1;
   localparam logic [SelW-1:0] PortSel  = SelW'(PORT);
   localparam logic [7:0]      TcntLast = 8'(TIMEOUT - 1);

   localparam logic [2:0] CmdIdle  = 3'b000;
   localparam logic [2:0] CmdRd    = 3'b010;
   localparam logic [1:0] RespNull = 2'b00;
   localparam logic [1:0] RespErr  = 2'b11;
   localparam logic       OwnI     = 1'b0;
   localparam logic       OwnD     = 1'b1;

   typedef enum logic [1:0] {StIdle, StCmd, StResp} state_e;

   state_e     state_q;
   logic       owner_q;
   logic       last_q;
   logic       cmd_is_rd_q;
   logic [7:0] tcnt_q;

   logic        req_i;
   logic        req_d;
   logic        grant;
   logic [31:0] own_addr;
   logic [2:0]  own_cmd;
   logic [31:0] own_data;
   logic [3:0]  own_be;
   logic        fwd;
   logic        slave_done;
   logic        timeout_done;
   logic [31:0] resp_data;
   logic [1:0]  resp_code;

   always_comb begin
      req_i = (bus.i_I_MCmd != CmdIdle) && (bus.i_I_MAddr[SEL_MSB:SEL_LSB] == PortSel);
      req_d = (bus.i_D_MCmd != CmdIdle) && (bus.i_D_MAddr[SEL_MSB:SEL_LSB] == PortSel);
      // A tie goes to whichever master did not win the previous grant.
      if (req_i && req_d) begin
         grant = ~last_q;
      end else begin
         grant = req_d ? OwnD : OwnI;
      end
   end

   always_comb begin
      if (owner_q == OwnD) begin
         own_addr = bus.i_D_MAddr;
         own_cmd  = bus.i_D_MCmd;
         own_data = bus.i_D_MData;
         own_be   = bus.i_D_MByteEn;
      end else begin
         own_addr = bus.i_I_MAddr;
         own_cmd  = bus.i_I_MCmd;
         own_data = bus.i_I_MData;
         own_be   = bus.i_I_MByteEn;
      end
      fwd          = (state_q == StCmd) && (own_cmd != CmdIdle);
      slave_done   = (state_q == StResp) && cmd_is_rd_q && (bus.i_P_SResp != RespNull);
      timeout_done = (state_q == StResp) && !slave_done && (tcnt_q == TcntLast);
   end

   always_comb begin
      bus.o_P_MAddr   = fwd ? own_addr : '0;
      bus.o_P_MCmd    = fwd ? own_cmd  : CmdIdle;
      bus.o_P_MData   = fwd ? own_data : '0;
      bus.o_P_MByteEn = fwd ? own_be   : '0;

      resp_data = '0;
      resp_code = RespNull;
      if (slave_done) begin
         resp_data = bus.i_P_SData;
         resp_code = bus.i_P_SResp;
      end else if (timeout_done) begin
         resp_code = RespErr;
      end

      bus.o_I_SData = (owner_q == OwnI) ? resp_data : '0;
      bus.o_I_SResp = (owner_q == OwnI) ? resp_code : RespNull;
      bus.o_D_SData = (owner_q == OwnD) ? resp_data : '0;
      bus.o_D_SResp = (owner_q == OwnD) ? resp_code : RespNull;

      // A requesting master is stalled unless it owns the port in the command phase.
      bus.o_I_SCmdAccept = !req_i ||
                           ((state_q == StCmd) && (owner_q == OwnI) && bus.i_P_SCmdAccept);
      bus.o_D_SCmdAccept = !req_d ||
                           ((state_q == StCmd) && (owner_q == OwnD) && bus.i_P_SCmdAccept);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         owner_q     <= OwnI;
         last_q      <= OwnD;
         cmd_is_rd_q <= 1'b0;
         tcnt_q      <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (req_i || req_d) begin
                  owner_q <= grant;
                  last_q  <= grant;
                  state_q <= StCmd;
               end
            end
            StCmd: begin
               if (own_cmd == CmdIdle) begin
                  state_q <= StIdle;
               end else if (bus.i_P_SCmdAccept) begin
                  if (own_cmd == CmdRd) begin
                     state_q     <= StResp;
                     tcnt_q      <= '0;
                     cmd_is_rd_q <= 1'b1;
                  end else begin
                     // Writes complete at accept; no response will follow.
                     state_q     <= StIdle;
                     cmd_is_rd_q <= 1'b0;
                  end
               end
            end
            StResp: begin
               if (slave_done || timeout_done) begin
                  state_q     <= StIdle;
                  cmd_is_rd_q <= 1'b0;
               end else begin
                  tcnt_q <= tcnt_q + 8'd1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_fabric_port_arbiter.sv
// Self-checking bench for fabric_port_arbiter: directed scenarios plus randomized
// transactions checked against a timeline model of the arbitration rules.
module tb_fabric_port_arbiter;

   localparam int unsigned T = 4;
   localparam logic [2:0] IDL = 3'b000;
   localparam logic [2:0] WR  = 3'b001;
   localparam logic [2:0] RD  = 3'b010;

   logic clk;
   logic rst;
   int   errors;
   int   checks;
   int   model_last;  // 0 = I, 1 = D: master granted most recently

   fabric_port_arbiter_if bus ();

   fabric_port_arbiter #(
      .PORT    (1),
      .SEL_MSB (31),
      .SEL_LSB (29),
      .TIMEOUT (T)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic drive_m(input int m, input logic [2:0] cmd, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] be);
      if (m == 0) begin
         bus.i_I_MCmd = cmd; bus.i_I_MAddr = addr; bus.i_I_MData = data; bus.i_I_MByteEn = be;
      end else begin
         bus.i_D_MCmd = cmd; bus.i_D_MAddr = addr; bus.i_D_MData = data; bus.i_D_MByteEn = be;
      end
   endtask

   task automatic drive_s(input logic acc, input logic [1:0] resp, input logic [31:0] data);
      bus.i_P_SCmdAccept = acc;
      bus.i_P_SResp      = resp;
      bus.i_P_SData      = data;
   endtask

   task automatic clear_all();
      drive_m(0, IDL, 32'h0, 32'h0, 4'h0);
      drive_m(1, IDL, 32'h0, 32'h0, 4'h0);
      drive_s(1'b0, 2'b00, 32'h0);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      clear_all();
      next_cycle();
      next_cycle();
      rst = 1'b0;
      model_last = 1;
   endtask

   function automatic logic get_acc(input int m);
      return (m == 0) ? bus.o_I_SCmdAccept : bus.o_D_SCmdAccept;
   endfunction

   function automatic logic [1:0] get_resp(input int m);
      return (m == 0) ? bus.o_I_SResp : bus.o_D_SResp;
   endfunction

   function automatic logic [31:0] get_data(input int m);
      return (m == 0) ? bus.o_I_SData : bus.o_D_SData;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      clear_all();
      sample();
      checks++; if (bus.o_P_MCmd !== IDL) begin errors++;
         $display("FAIL rst_pcmd got=%h exp=%h", bus.o_P_MCmd, IDL); end
      checks++; if (bus.o_P_MAddr !== 32'h0) begin errors++;
         $display("FAIL rst_paddr got=%h exp=0", bus.o_P_MAddr); end
      checks++; if (bus.o_I_SCmdAccept !== 1'b1 || bus.o_D_SCmdAccept !== 1'b1) begin errors++;
         $display("FAIL rst_acc got=%b%b exp=11", bus.o_I_SCmdAccept, bus.o_D_SCmdAccept); end
      checks++; if (bus.o_I_SResp !== 2'b00 || bus.o_D_SResp !== 2'b00) begin errors++;
         $display("FAIL rst_resp got=%h/%h exp=0/0", bus.o_I_SResp, bus.o_D_SResp); end
      next_cycle();
      drive_m(0, RD, 32'h2000_0000, 32'h0, 4'hF);
      sample();
      checks++; if (bus.o_I_SCmdAccept !== 1'b0 || bus.o_D_SCmdAccept !== 1'b1) begin errors++;
         $display("FAIL rst_req_acc got=%b%b exp=01", bus.o_I_SCmdAccept, bus.o_D_SCmdAccept); end
      next_cycle();
      clear_all();
      rst = 1'b0;
      model_last = 1;
      for (int c = 0; c < 3; c++) begin
         sample();
         checks++; if (bus.o_P_MCmd !== IDL || bus.o_I_SCmdAccept !== 1'b1) begin errors++;
            $display("FAIL idle_hold got=%h/%b exp=0/1", bus.o_P_MCmd, bus.o_I_SCmdAccept); end
         next_cycle();
      end
   endtask

   task automatic test_single_read();
      apply_reset();
      drive_m(0, RD, 32'h2000_0010, 32'h0, 4'hF);
      sample();
      checks++; if (bus.o_P_MCmd !== IDL || bus.o_I_SCmdAccept !== 1'b0) begin errors++;
         $display("FAIL sr_arb got=%h/%b exp=0/0", bus.o_P_MCmd, bus.o_I_SCmdAccept); end
      next_cycle();
      drive_s(1'b1, 2'b00, 32'h0);
      sample();
      checks++; if (bus.o_P_MCmd !== RD || bus.o_P_MAddr !== 32'h2000_0010) begin errors++;
         $display("FAIL sr_fwd got=%h/%h exp=%h/20000010", bus.o_P_MCmd, bus.o_P_MAddr, RD); end
      checks++; if (bus.o_I_SCmdAccept !== 1'b1 || bus.o_D_SCmdAccept !== 1'b1) begin errors++;
         $display("FAIL sr_acc got=%b%b exp=11", bus.o_I_SCmdAccept, bus.o_D_SCmdAccept); end
      next_cycle();
      drive_m(0, IDL, 32'h0, 32'h0, 4'h0);
      drive_s(1'b0, 2'b00, 32'h0);
      sample();
      checks++; if (bus.o_I_SResp !== 2'b00 || bus.o_P_MCmd !== IDL) begin errors++;
         $display("FAIL sr_wait got=%h/%h exp=0/0", bus.o_I_SResp, bus.o_P_MCmd); end
      next_cycle();
      drive_s(1'b0, 2'b01, 32'hCAFE_BABE);
      sample();
      checks++; if (bus.o_I_SData !== 32'hCAFE_BABE || bus.o_I_SResp !== 2'b01) begin errors++;
         $display("FAIL sr_resp got=%h/%h exp=cafebabe/1", bus.o_I_SData, bus.o_I_SResp); end
      checks++; if (bus.o_D_SData !== 32'h0 || bus.o_D_SResp !== 2'b00) begin errors++;
         $display("FAIL sr_d_neutral got=%h/%h exp=0/0", bus.o_D_SData, bus.o_D_SResp); end
      next_cycle();
      drive_s(1'b0, 2'b00, 32'h0);
      sample();
      checks++; if (bus.o_I_SResp !== 2'b00) begin errors++;
         $display("FAIL sr_after got=%h exp=0", bus.o_I_SResp); end
      next_cycle();
   endtask

   task automatic test_tie();
      apply_reset();
      drive_m(0, RD, 32'h2000_0020, 32'h0, 4'hF);
      drive_m(1, WR, 32'h2000_0100, 32'h1234_5678, 4'hA);
      sample();
      checks++; if (bus.o_I_SCmdAccept !== 1'b0 || bus.o_D_SCmdAccept !== 1'b0) begin errors++;
         $display("FAIL tie_arb got=%b%b exp=00", bus.o_I_SCmdAccept, bus.o_D_SCmdAccept); end
      next_cycle();
      drive_s(1'b1, 2'b00, 32'h0);
      sample();
      checks++; if (bus.o_P_MAddr !== 32'h2000_0020 || bus.o_P_MCmd !== RD) begin errors++;
         $display("FAIL tie_first got=%h/%h exp=20000020/%h", bus.o_P_MAddr, bus.o_P_MCmd, RD); end
      checks++; if (bus.o_I_SCmdAccept !== 1'b1 || bus.o_D_SCmdAccept !== 1'b0) begin errors++;
         $display("FAIL tie_acc got=%b%b exp=10", bus.o_I_SCmdAccept, bus.o_D_SCmdAccept); end
      next_cycle();
      drive_m(0, IDL, 32'h0, 32'h0, 4'h0);
      drive_s(1'b0, 2'b01, 32'h0000_55AA);
      sample();
      checks++; if (bus.o_I_SResp !== 2'b01 || bus.o_I_SData !== 32'h55AA) begin errors++;
         $display("FAIL tie_iresp got=%h/%h exp=1/55aa", bus.o_I_SResp, bus.o_I_SData); end
      checks++; if (bus.o_D_SCmdAccept !== 1'b0 || bus.o_D_SResp !== 2'b00) begin errors++;
         $display("FAIL tie_dstall got=%b/%h exp=0/0", bus.o_D_SCmdAccept, bus.o_D_SResp); end
      next_cycle();
      drive_s(1'b0, 2'b00, 32'h0);
      sample();
      checks++; if (bus.o_P_MCmd !== IDL || bus.o_D_SCmdAccept !== 1'b0) begin errors++;
         $display("FAIL tie_darb got=%h/%b exp=0/0", bus.o_P_MCmd, bus.o_D_SCmdAccept); end
      next_cycle();
      drive_s(1'b1, 2'b00, 32'h0);
      sample();
      checks++; if (bus.o_P_MCmd !== WR || bus.o_P_MData !== 32'h1234_5678 ||
                    bus.o_P_MByteEn !== 4'hA || bus.o_P_MAddr !== 32'h2000_0100) begin errors++;
         $display("FAIL tie_dfwd got=%h/%h/%h exp=%h/12345678/a",
                  bus.o_P_MCmd, bus.o_P_MData, bus.o_P_MByteEn, WR); end
      checks++; if (bus.o_D_SCmdAccept !== 1'b1) begin errors++;
         $display("FAIL tie_dacc got=%b exp=1", bus.o_D_SCmdAccept); end
      next_cycle();
      drive_m(0, WR, 32'h2000_0030, 32'h1, 4'hF);
      drive_m(1, WR, 32'h2000_0200, 32'h2, 4'hF);
      drive_s(1'b0, 2'b00, 32'h0);
      sample();
      next_cycle();
      drive_s(1'b1, 2'b00, 32'h0);
      sample();
      checks++; if (bus.o_P_MAddr !== 32'h2000_0030) begin errors++;
         $display("FAIL tie_second got=%h exp=20000030", bus.o_P_MAddr); end
      next_cycle();
      drive_m(0, IDL, 32'h0, 32'h0, 4'h0);
      sample();
      next_cycle();
      sample();
      checks++; if (bus.o_P_MAddr !== 32'h2000_0200 || bus.o_D_SCmdAccept !== 1'b1) begin errors++;
         $display("FAIL tie_third got=%h/%b exp=20000200/1", bus.o_P_MAddr, bus.o_D_SCmdAccept); end
      next_cycle();
      clear_all();
   endtask

   task automatic test_write_no_resp();
      apply_reset();
      drive_m(1, WR, 32'h2000_0400, 32'hA5A5_0001, 4'h3);
      drive_s(1'b0, 2'b01, 32'hDEAD_0001);
      sample();
      checks++; if (bus.o_D_SResp !== 2'b00 || bus.o_I_SResp !== 2'b00) begin errors++;
         $display("FAIL wr_stray_idle got=%h/%h exp=0/0", bus.o_D_SResp, bus.o_I_SResp); end
      next_cycle();
      drive_s(1'b1, 2'b01, 32'hDEAD_0001);
      sample();
      checks++; if (bus.o_P_MCmd !== WR || bus.o_D_SCmdAccept !== 1'b1) begin errors++;
         $display("FAIL wr_fwd got=%h/%b exp=%h/1", bus.o_P_MCmd, bus.o_D_SCmdAccept, WR); end
      checks++; if (bus.o_D_SResp !== 2'b00 || bus.o_D_SData !== 32'h0) begin errors++;
         $display("FAIL wr_stray_cmd got=%h/%h exp=0/0", bus.o_D_SResp, bus.o_D_SData); end
      next_cycle();
      drive_m(1, WR, 32'h2000_0800, 32'hA5A5_0002, 4'hC);
      sample();
      checks++; if (bus.o_P_MCmd !== IDL || bus.o_D_SCmdAccept !== 1'b0 ||
                    bus.o_D_SResp !== 2'b00) begin errors++;
         $display("FAIL wr_to_idle got=%h/%b/%h exp=0/0/0",
                  bus.o_P_MCmd, bus.o_D_SCmdAccept, bus.o_D_SResp); end
      next_cycle();
      sample();
      checks++; if (bus.o_P_MCmd !== WR || bus.o_P_MAddr !== 32'h2000_0800) begin errors++;
         $display("FAIL wr_b2b got=%h/%h exp=%h/20000800", bus.o_P_MCmd, bus.o_P_MAddr, WR); end
      next_cycle();
      clear_all();
      next_cycle();
   endtask

   task automatic test_timeout();
      apply_reset();
      drive_m(0, RD, 32'h2000_0040, 32'h0, 4'hF);
      next_cycle();
      drive_s(1'b1, 2'b00, 32'h0);
      next_cycle();
      drive_m(0, IDL, 32'h0, 32'h0, 4'h0);
      drive_s(1'b0, 2'b00, 32'h0);
      for (int c = 1; c < 4; c++) begin
         sample();
         checks++; if (bus.o_I_SResp !== 2'b00) begin errors++;
            $display("FAIL to_wait%0d got=%h exp=0", c, bus.o_I_SResp); end
         next_cycle();
      end
      sample();
      checks++; if (bus.o_I_SResp !== 2'b11 || bus.o_I_SData !== 32'h0) begin errors++;
         $display("FAIL to_err got=%h/%h exp=3/0", bus.o_I_SResp, bus.o_I_SData); end
      next_cycle();
      drive_s(1'b0, 2'b01, 32'h1111_2222);
      sample();
      checks++; if (bus.o_I_SResp !== 2'b00 || bus.o_I_SData !== 32'h0) begin errors++;
         $display("FAIL to_stray got=%h/%h exp=0/0", bus.o_I_SResp, bus.o_I_SData); end
      next_cycle();
      clear_all();
   endtask

   task automatic test_protocol_violation();
      apply_reset();
      drive_m(0, RD, 32'h2000_0050, 32'h0, 4'hF);
      next_cycle();
      sample();
      checks++; if (bus.o_I_SCmdAccept !== 1'b0 || bus.o_P_MCmd !== RD) begin errors++;
         $display("FAIL pv_hold got=%b/%h exp=0/%h", bus.o_I_SCmdAccept, bus.o_P_MCmd, RD); end
      next_cycle();
      drive_m(0, IDL, 32'h0, 32'h0, 4'h0);
      sample();
      checks++; if (bus.o_P_MCmd !== IDL || bus.o_I_SCmdAccept !== 1'b1) begin errors++;
         $display("FAIL pv_drop got=%h/%b exp=0/1", bus.o_P_MCmd, bus.o_I_SCmdAccept); end
      next_cycle();
      drive_s(1'b0, 2'b01, 32'h7777);
      sample();
      checks++; if (bus.o_I_SResp !== 2'b00) begin errors++;
         $display("FAIL pv_noresp got=%h exp=0", bus.o_I_SResp); end
      next_cycle();
      clear_all();
   endtask

   task automatic test_reset_mid();
      apply_reset();
      drive_m(0, RD, 32'h2000_0060, 32'h0, 4'hF);
      next_cycle();
      drive_s(1'b1, 2'b00, 32'h0);
      next_cycle();
      drive_m(0, IDL, 32'h0, 32'h0, 4'h0);
      drive_s(1'b0, 2'b00, 32'h0);
      next_cycle();
      drive_s(1'b0, 2'b01, 32'hBEEF);
      #1 rst = 1'b1;
      sample();
      checks++; if (bus.o_I_SResp !== 2'b00 || bus.o_I_SData !== 32'h0) begin errors++;
         $display("FAIL rm_resp got=%h/%h exp=0/0", bus.o_I_SResp, bus.o_I_SData); end
      checks++; if (bus.o_P_MCmd !== IDL || bus.o_I_SCmdAccept !== 1'b1 ||
                    bus.o_D_SCmdAccept !== 1'b1) begin errors++;
         $display("FAIL rm_outs got=%h/%b%b exp=0/11",
                  bus.o_P_MCmd, bus.o_I_SCmdAccept, bus.o_D_SCmdAccept); end
      next_cycle();
      rst = 1'b0;
      model_last = 1;
      sample();
      checks++; if (bus.o_I_SResp !== 2'b00) begin errors++;
         $display("FAIL rm_after got=%h exp=0", bus.o_I_SResp); end
      next_cycle();
      clear_all();
   endtask

   // Single-master transactions with random latencies; expected outputs come from
   // a timeline: grant cycle, k stalled cycles, accept, then response or timeout.
   task automatic test_random_txn();
      apply_reset();
      for (int n = 0; n < 30; n++) begin
         int          m, o, k, r;
         logic        rd;
         logic [2:0]  cmd, sel, ocmd;
         logic [31:0] addr, data, rdata;
         logic [3:0]  be;
         logic [1:0]  code, exp_resp;
         logic [31:0] exp_data;
         m    = $urandom_range(0, 1);
         o    = 1 - m;
         rd   = 1'($urandom_range(0, 1));
         cmd  = rd ? RD : WR;
         k    = $urandom_range(0, 2);
         r    = $urandom_range(1, 6);
         addr = {3'b001, 29'($urandom)};
         data = $urandom;
         be   = 4'($urandom);
         rdata = $urandom;
         code = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b01;
         sel  = 3'($urandom_range(0, 6));
         if (sel >= 3'd1) sel = sel + 3'd1;
         ocmd = 3'($urandom_range(0, 2));
         drive_m(m, cmd, addr, data, be);
         drive_m(o, ocmd, {sel, 29'($urandom)}, $urandom, 4'hF);
         drive_s(1'b0, 2'b00, 32'h0);
         sample();
         checks++; if (bus.o_P_MCmd !== IDL || get_acc(m) !== 1'b0 || get_acc(o) !== 1'b1)
            begin errors++;
            $display("FAIL rnd_arb n=%0d got=%h/%b%b exp=0/01", n, bus.o_P_MCmd, get_acc(m),
                     get_acc(o)); end
         model_last = m;
         next_cycle();
         for (int j = 0; j <= k; j++) begin
            drive_s(j == k, 2'b00, 32'h0);
            sample();
            checks++; if (bus.o_P_MCmd !== cmd || bus.o_P_MAddr !== addr ||
                          bus.o_P_MData !== data || bus.o_P_MByteEn !== be) begin errors++;
               $display("FAIL rnd_fwd n=%0d got=%h/%h/%h exp=%h/%h/%h", n, bus.o_P_MCmd,
                        bus.o_P_MAddr, bus.o_P_MData, cmd, addr, data); end
            checks++; if (get_acc(m) !== (j == k) || get_acc(o) !== 1'b1) begin errors++;
               $display("FAIL rnd_acc n=%0d j=%0d got=%b%b exp=%b1", n, j, get_acc(m),
                        get_acc(o), (j == k)); end
            next_cycle();
         end
         drive_m(m, IDL, 32'h0, 32'h0, 4'h0);
         drive_s(1'b0, 2'b00, 32'h0);
         if (rd) begin
            for (int c = 1; c <= int'(T); c++) begin
               exp_resp = 2'b00;
               exp_data = 32'h0;
               if (c == r) begin
                  drive_s(1'b0, code, rdata);
                  exp_resp = code;
                  exp_data = rdata;
               end else if (c == int'(T)) begin
                  exp_resp = 2'b11;
               end
               sample();
               checks++; if (get_resp(m) !== exp_resp || get_data(m) !== exp_data) begin
                  errors++;
                  $display("FAIL rnd_resp n=%0d c=%0d got=%h/%h exp=%h/%h", n, c, get_resp(m),
                           get_data(m), exp_resp, exp_data); end
               checks++; if (get_resp(o) !== 2'b00 || bus.o_P_MCmd !== IDL) begin errors++;
                  $display("FAIL rnd_other n=%0d got=%h/%h exp=0/0", n, get_resp(o),
                           bus.o_P_MCmd); end
               next_cycle();
               drive_s(1'b0, 2'b00, 32'h0);
               if (exp_resp != 2'b00) break;
            end
         end
      end
      clear_all();
      next_cycle();
   endtask

   // Random mix of ties and single requests; the winner of a tie is the master
   // that was not granted last.
   task automatic test_random_tie();
      for (int n = 0; n < 12; n++) begin
         int          mode, w, l;
         logic [31:0] a[2];
         mode = $urandom_range(0, 2);
         a[0] = {3'b001, 29'($urandom)};
         a[1] = {3'b001, 29'($urandom)};
         if (mode == 0) w = 1 - model_last;
         else w = mode - 1;
         l = 1 - w;
         drive_m(w, WR, a[w], 32'h0, 4'hF);
         if (mode == 0) drive_m(l, WR, a[l], 32'h0, 4'hF);
         next_cycle();
         drive_s(1'b1, 2'b00, 32'h0);
         sample();
         checks++; if (bus.o_P_MAddr !== a[w] || get_acc(w) !== 1'b1 ||
                       get_acc(l) !== (mode != 0)) begin errors++;
            $display("FAIL rtie_win n=%0d got=%h/%b%b exp=%h", n, bus.o_P_MAddr, get_acc(w),
                     get_acc(l), a[w]); end
         model_last = w;
         next_cycle();
         drive_m(w, IDL, 32'h0, 32'h0, 4'h0);
         if (mode == 0) begin
            next_cycle();
            sample();
            checks++; if (bus.o_P_MAddr !== a[l] || get_acc(l) !== 1'b1) begin errors++;
               $display("FAIL rtie_lose n=%0d got=%h/%b exp=%h/1", n, bus.o_P_MAddr,
                        get_acc(l), a[l]); end
            model_last = l;
            next_cycle();
            drive_m(l, IDL, 32'h0, 32'h0, 4'h0);
         end
         drive_s(1'b0, 2'b00, 32'h0);
      end
      clear_all();
      next_cycle();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      model_last = 1;
      rst = 1'b1;
      clear_all();
      next_cycle();
      test_reset();
      test_single_read();
      test_tie();
      test_write_no_resp();
      test_timeout();
      test_protocol_violation();
      test_reset_mid();
      test_random_txn();
      test_random_tie();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
